// File: rtl/y86_pkg.sv
// Shared Y86 definitions: loader state encodings, fetch window size, core status codes.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package y86_pkg;

  // Longest Y86 instruction in bytes; sets the width of the fetch window.
  localparam int FETCH_BYTES = 10;

  // Instruction-memory loader states.
  typedef enum logic [1:0] {
    IMEM_IDLE  = 2'd0,
    IMEM_LOAD  = 2'd1,
    IMEM_DONE  = 2'd2,
    IMEM_ERROR = 2'd3
  } imem_state_t;

  // Processor status codes consumed by the core's status logic.
  typedef enum logic [2:0] {
    AOK = 3'd1,
    ADR = 3'd2,
    INS = 3'd3,
    HLT = 3'd4
  } stat_t;

endpackage

// File: rtl/imem_ram.sv
// Byte-wide instruction RAM: one write port, one registered FETCH_BYTES-wide read window.
// Latency: write lands at the clock edge; read window, valid and address error register one cycle after i_pc.
// Backpressure: none; i_rd_en low freezes the window and address-error flag and drops o_vld.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset (read registers only, RAM not cleared)
//   i_we/i_waddr/i_wdata  byte write port
//   i_rd_en, i_pc         read enable and 64-bit window start address
//   o_window              bits [0:7] = mem[pc], [8:15] = mem[pc+1], ...; out-of-range bytes read 0
//   o_vld, o_adr_err      window valid, window runs past the end of memory
module imem_ram
  import y86_pkg::*;
#(
  parameter int MEM_BYTES = 2048,
  parameter int ADDR_W    = 11
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_we,
  input  logic [ADDR_W-1:0]        i_waddr,
  input  logic [7:0]               i_wdata,
  input  logic                     i_rd_en,
  input  logic [63:0]              i_pc,
  output logic [0:FETCH_BYTES*8-1] o_window,
  output logic                     o_vld,
  output logic                     o_adr_err
);

  logic [7:0]               r_mem [MEM_BYTES];
  logic [0:FETCH_BYTES*8-1] r_window;
  logic                     r_vld;
  logic                     r_adr_err;
  logic [0:FETCH_BYTES*8-1] w_window;
  logic                     w_adr_err;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Byte addresses are formed in 65 bits so a PC near 2^64 cannot wrap
  // back into the valid range and alias low memory.
  for (genvar k = 0; k < FETCH_BYTES; k++) begin : g_rd
    logic [64:0] w_addr;
    assign w_addr = {1'b0, i_pc} + 65'(k);
    assign w_window[k*8 +: 8] = (w_addr < 65'(MEM_BYTES)) ? r_mem[w_addr[ADDR_W-1:0]] : 8'h00;
  end

  assign w_adr_err = ({1'b0, i_pc} + 65'(FETCH_BYTES)) > 65'(MEM_BYTES);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_window  <= '0;
      r_vld     <= 1'b0;
      r_adr_err <= 1'b0;
    end else begin
      r_vld <= i_rd_en;
      if (i_rd_en) begin
        r_window  <= w_window;
        r_adr_err <= w_adr_err;
      end
    end
  end

  assign o_window  = r_window;
  assign o_vld     = r_vld;
  assign o_adr_err = r_adr_err;

endmodule

// File: rtl/imem_loader.sv
// Synthesizable program loader and fetch port for the sequential Y86 core.
// Latency: one byte accepted per cycle while loading; fetch window valid one cycle after PC.
// Backpressure: In_Ready high only while loading; In_Valid low stalls the load indefinitely.
//
// Ports:
//   Clk, Rst                       clock, synchronous active-high reset
//   Load_Start, Load_Len           load request pulse and program byte count
//   In_Valid, In_Byte, In_Ready    byte stream handshake
//   Busy, Done, Load_Error         load status levels
//   Cpu_Hold                       core must not advance PC while high
//   PC, Instruction, Fetch_Valid,  fetch address in, registered 10-byte window out
//   Fetch_Adr_Err                  window runs past the end of memory
module imem_loader
  import y86_pkg::*;
#(
  parameter int MEM_BYTES = 2048,
  parameter int ADDR_W    = 11
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     Load_Start,
  input  logic [ADDR_W:0]          Load_Len,
  input  logic                     In_Valid,
  input  logic [7:0]               In_Byte,
  output logic                     In_Ready,
  output logic                     Busy,
  output logic                     Done,
  output logic                     Load_Error,
  output logic                     Cpu_Hold,
  input  logic [63:0]              PC,
  output logic [0:FETCH_BYTES*8-1] Instruction,
  output logic                     Fetch_Valid,
  output logic                     Fetch_Adr_Err
);

  localparam logic [ADDR_W:0] MAX_LEN = MEM_BYTES[ADDR_W:0];
  localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};

  imem_state_t     r_state;
  logic [ADDR_W:0] r_len;
  logic [ADDR_W:0] r_cnt;
  logic            r_in_ready;
  logic            r_busy;
  logic            r_done;
  logic            r_load_error;
  logic            r_cpu_hold;

  logic            w_len_ok;
  logic            w_accept;
  logic            w_last;
  logic            w_rd_en;

  assign w_len_ok = (Load_Len != '0) && (Load_Len <= MAX_LEN);
  // r_in_ready is only ever set while in LOAD, so it doubles as the state qualifier.
  assign w_accept = r_in_ready && In_Valid;
  assign w_last   = (r_cnt + ONE) == r_len;
  assign w_rd_en  = (r_state == IMEM_DONE);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state      <= IMEM_IDLE;
      r_len        <= '0;
      r_cnt        <= '0;
      r_in_ready   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_load_error <= 1'b0;
      r_cpu_hold   <= 1'b1;
    end else begin
      case (r_state)
        IMEM_LOAD: begin
          // Load_Start is ignored here, including on the final-byte cycle.
          if (w_accept) begin
            r_cnt <= r_cnt + ONE;
            if (w_last) begin
              r_state    <= IMEM_DONE;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
              r_cpu_hold <= 1'b0;
            end
          end
        end
        default: begin
          // IDLE, DONE and ERROR all take a new request under the same rules.
          if (Load_Start) begin
            if (w_len_ok) begin
              r_state      <= IMEM_LOAD;
              r_len        <= Load_Len;
              r_cnt        <= '0;
              r_in_ready   <= 1'b1;
              r_busy       <= 1'b1;
              r_done       <= 1'b0;
              r_load_error <= 1'b0;
              r_cpu_hold   <= 1'b1;
            end else begin
              r_state      <= IMEM_ERROR;
              r_in_ready   <= 1'b0;
              r_busy       <= 1'b0;
              r_done       <= 1'b0;
              r_load_error <= 1'b1;
              r_cpu_hold   <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign In_Ready   = r_in_ready;
  assign Busy       = r_busy;
  assign Done       = r_done;
  assign Load_Error = r_load_error;
  assign Cpu_Hold   = r_cpu_hold;

  imem_ram #(
    .MEM_BYTES (MEM_BYTES),
    .ADDR_W    (ADDR_W)
  ) u_ram (
    .i_clk     (Clk),
    .i_rst     (Rst),
    .i_we      (w_accept),
    .i_waddr   (r_cnt[ADDR_W-1:0]),
    .i_wdata   (In_Byte),
    .i_rd_en   (w_rd_en),
    .i_pc      (PC),
    .o_window  (Instruction),
    .o_vld     (Fetch_Valid),
    .o_adr_err (Fetch_Adr_Err)
  );

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  localparam int MEMB = 2048;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start;
  logic [11:0] load_len;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        in_ready;
  logic        busy;
  logic        done;
  logic        load_error;
  logic        cpu_hold;
  logic [63:0] pc;
  logic [0:79] instr;
  logic        fetch_valid;
  logic        fetch_adr_err;

  initial forever #5 clk = ~clk;

  imem_loader #(.MEM_BYTES(2048), .ADDR_W(11)) dut (
    .Clk           (clk),
    .Rst           (rst),
    .Load_Start    (load_start),
    .Load_Len      (load_len),
    .In_Valid      (in_valid),
    .In_Byte       (in_byte),
    .In_Ready      (in_ready),
    .Busy          (busy),
    .Done          (done),
    .Load_Error    (load_error),
    .Cpu_Hold      (cpu_hold),
    .PC            (pc),
    .Instruction   (instr),
    .Fetch_Valid   (fetch_valid),
    .Fetch_Adr_Err (fetch_adr_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b, required %b", name, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Load status as three flags plus a bytes-remaining count; memory as a plain array.
  logic [7:0]  m_mem [MEMB];
  bit          m_loading = 1'b0;
  bit          m_loaded  = 1'b0;
  bit          m_bad     = 1'b0;
  bit          m_live    = 1'b0;
  int          m_left    = 0;
  int          m_wr      = 0;
  logic [79:0] e_instr   = '0;
  bit          e_fv      = 1'b0;
  bit          e_ae      = 1'b0;
  logic [64:0] m_a;
  logic [79:0] m_win;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_loading = 1'b0;
      m_loaded  = 1'b0;
      m_bad     = 1'b0;
      e_instr   = '0;
      e_fv      = 1'b0;
      e_ae      = 1'b0;
      m_live    = 1'b1;
    end else if (m_live) begin
      // Fetch reflects the status before this edge.
      e_fv = m_loaded;
      if (m_loaded) begin
        m_win = '0;
        for (int k = 0; k < 10; k++) begin
          m_a   = {1'b0, pc} + 65'(k);
          m_win = {m_win[71:0], (m_a < 65'(MEMB)) ? m_mem[m_a[10:0]] : 8'h00};
        end
        e_instr = m_win;
        e_ae    = ({1'b0, pc} + 65'd10) > 65'(MEMB);
      end
      if (m_loading) begin
        if (in_valid) begin
          m_mem[m_wr] = in_byte;
          m_wr++;
          m_left--;
          if (m_left == 0) begin
            m_loading = 1'b0;
            m_loaded  = 1'b1;
          end
        end
      end else if (load_start) begin
        if (load_len != 12'd0 && load_len <= 12'd2048) begin
          m_loading = 1'b1;
          m_loaded  = 1'b0;
          m_bad     = 1'b0;
          m_left    = int'(load_len);
          m_wr      = 0;
        end else begin
          m_bad    = 1'b1;
          m_loaded = 1'b0;
        end
      end
    end
  end

  // Cycle-by-cycle compare against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (m_live) begin
      check_vec("status", 80'({in_ready, busy, done, load_error, cpu_hold}),
                80'({m_loading, m_loading, m_loaded, m_bad, !m_loaded}));
      check_vec("instruction", instr, e_instr);
      check_bit("fetch_valid", fetch_valid, e_fv);
      check_bit("fetch_adr_err", fetch_adr_err, e_ae);
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] sbytes [MEMB];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic start_load(input logic [11:0] len);
    load_start = 1'b1;
    load_len   = len;
    tick();
    load_start = 1'b0;
  endtask

  // Streams sbytes[0..n-1]; optionally toggles In_Valid and raises Load_Start on the last byte.
  task automatic stream(input int n, input bit toggle, input bit start_on_last,
                        output int rdy_seen, output int bad_seen);
    int sent = 0;
    int cyc  = 0;
    bit v    = 1'b1;
    bit acc;
    rdy_seen = 0;
    bad_seen = 0;
    while (sent < n && cyc < 3*n + 20) begin
      in_valid   = v;
      in_byte    = sbytes[sent];
      load_start = start_on_last && (sent == n - 1);
      load_len   = 12'd7;
      if (in_ready) rdy_seen++;
      if (!busy || done) bad_seen++;
      acc = v && in_ready;
      tick();
      if (acc) sent++;
      if (toggle) v = !v;
      cyc++;
    end
    in_valid   = 1'b0;
    load_start = 1'b0;
    check_int("stream_bytes_sent", sent, n);
  endtask

  initial begin
    int rdy;
    int bad;
    rst = 1'b1; load_start = 1'b0; load_len = '0; in_valid = 1'b0; in_byte = '0; pc = '0;
    tick(); tick();
    check_bit("rst_in_ready", in_ready, 1'b0);
    check_bit("rst_busy", busy, 1'b0);
    check_bit("rst_done", done, 1'b0);
    check_bit("rst_load_error", load_error, 1'b0);
    check_bit("rst_cpu_hold", cpu_hold, 1'b1);
    check_vec("rst_instruction", instr, 80'h0);
    check_bit("rst_fetch_valid", fetch_valid, 1'b0);
    check_bit("rst_fetch_adr_err", fetch_adr_err, 1'b0);
    rst = 1'b0;

    // Fill memory with zeros so every later window is fully defined.
    for (int i = 0; i < MEMB; i++) sbytes[i] = 8'h00;
    start_load(12'd2048);
    stream(2048, 1'b0, 1'b0, rdy, bad);
    check_bit("prime_done", done, 1'b1);

    // 3-byte load with In_Valid held high.
    rst = 1'b1; tick(); rst = 1'b0;
    sbytes[0] = 8'h30; sbytes[1] = 8'hF4; sbytes[2] = 8'h0A;
    start_load(12'd3);
    stream(3, 1'b0, 1'b0, rdy, bad);
    check_int("t1_ready_cycles", rdy, 3);
    check_bit("t1_in_ready_low", in_ready, 1'b0);
    check_bit("t1_done", done, 1'b1);
    check_bit("t1_cpu_hold", cpu_hold, 1'b0);
    tick();
    check_vec("t1_instruction", instr, 80'h30F40A00000000000000);
    check_bit("t1_fetch_valid", fetch_valid, 1'b1);

    // 4-byte load with In_Valid toggling.
    sbytes[0] = 8'h11; sbytes[1] = 8'h22; sbytes[2] = 8'h33; sbytes[3] = 8'h44;
    start_load(12'd4);
    stream(4, 1'b1, 1'b0, rdy, bad);
    check_int("t2_ready_cycles", rdy, 7);
    check_int("t2_busy_or_early_done", bad, 0);
    check_bit("t2_done", done, 1'b1);
    tick();
    check_vec("t2_instruction", instr, 80'h11223344000000000000);

    // Bad lengths, then recovery.
    start_load(12'd0);
    check_bit("t3_err_len0", load_error, 1'b1);
    check_bit("t3_hold_len0", cpu_hold, 1'b1);
    check_bit("t3_ready_len0", in_ready, 1'b0);
    check_bit("t3_done_len0", done, 1'b0);
    start_load(12'd2049);
    check_bit("t3_err_len2049", load_error, 1'b1);
    tick();
    check_bit("t3_ready_len2049", in_ready, 1'b0);
    check_bit("t3_fetch_valid_err", fetch_valid, 1'b0);
    sbytes[0] = 8'h77;
    start_load(12'd1);
    check_bit("t3_busy", busy, 1'b1);
    check_bit("t3_err_cleared", load_error, 1'b0);
    stream(1, 1'b0, 1'b0, rdy, bad);
    check_bit("t3_done", done, 1'b1);
    tick();
    check_vec("t3_instruction", instr, 80'h77223344000000000000);

    // Full-memory load and end-of-memory windows.
    for (int i = 0; i < MEMB; i++) sbytes[i] = 8'(i);
    start_load(12'd2048);
    stream(2048, 1'b0, 1'b0, rdy, bad);
    check_bit("t4_done", done, 1'b1);
    pc = 64'd2040; tick();
    check_vec("t4_instr_2040", instr, 80'hF8F9FAFBFCFDFEFF0000);
    check_bit("t4_adr_err_2040", fetch_adr_err, 1'b1);
    pc = 64'd2038; tick();
    check_vec("t4_instr_2038", instr, 80'hF6F7F8F9FAFBFCFDFEFF);
    check_bit("t4_adr_err_2038", fetch_adr_err, 1'b0);
    pc = 64'd2039; tick();
    check_bit("t4_adr_err_2039", fetch_adr_err, 1'b1);
    pc = 64'hFFFF_FFFF_FFFF_FFFC; tick();
    check_vec("t4_instr_top", instr, 80'h0);
    check_bit("t4_adr_err_top", fetch_adr_err, 1'b1);
    pc = 64'd0; tick();
    check_vec("t4_instr_0", instr, 80'h00010203040506070809);

    // Reset partway through a 5-byte load.
    sbytes[0] = 8'hB0; sbytes[1] = 8'hB1;
    start_load(12'd5);
    stream(2, 1'b0, 1'b0, rdy, bad);
    rst = 1'b1; tick(); rst = 1'b0;
    check_bit("t5_done", done, 1'b0);
    check_bit("t5_cpu_hold", cpu_hold, 1'b1);
    check_bit("t5_in_ready", in_ready, 1'b0);
    check_bit("t5_busy", busy, 1'b0);
    sbytes[0] = 8'hC0;
    start_load(12'd1);
    stream(1, 1'b0, 1'b0, rdy, bad);
    tick();
    check_vec("t5_partial_kept", instr, 80'hC0B10203040506070809);
    sbytes[0] = 8'hA1; sbytes[1] = 8'hA2; sbytes[2] = 8'hA3; sbytes[3] = 8'hA4; sbytes[4] = 8'hA5;
    start_load(12'd5);
    stream(5, 1'b0, 1'b0, rdy, bad);
    check_bit("t5_reload_done", done, 1'b1);
    tick();
    check_vec("t5_instruction", instr, 80'hA1A2A3A4A50506070809);

    // Final byte and Load_Start in the same cycle.
    sbytes[0] = 8'hD0; sbytes[1] = 8'hD1;
    start_load(12'd2);
    stream(2, 1'b0, 1'b1, rdy, bad);
    check_bit("t6_done", done, 1'b1);
    check_bit("t6_in_ready", in_ready, 1'b0);
    check_bit("t6_busy", busy, 1'b0);
    tick();
    check_bit("t6_done_next", done, 1'b1);
    check_bit("t6_in_ready_next", in_ready, 1'b0);
    check_vec("t6_instruction", instr, 80'hD0D1A3A4A50506070809);

    tick(); tick();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, required completion before 500000");
    $fatal(1, "watchdog expired");
  end

endmodule
